// File: rtl/shift_sched_pkg.sv
// Shared constants, FSM state type and bit-reverse helper for the shift scheduler.
package shift_sched_pkg;

  localparam int DATA_W  = 16;
  localparam int SHAMT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [15:0] bitrev16(input logic [15:0] x);
    logic [15:0] y;
    for (int i = 0; i < 16; i++) begin
      y[i] = x[15-i];
    end
    return y;
  endfunction

endpackage

// File: rtl/barrel_right.sv
// Combinational logical right barrel shifter: one conditional power-of-two stage per shamt bit.
module barrel_right #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic [DATA_W-1:0]  din,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  dout
);

  logic [DATA_W-1:0] stage [SHAMT_W+1];

  assign stage[0] = din;

  for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
    assign stage[gi+1] = shamt[gi] ? (stage[gi] >> (1 << gi)) : stage[gi];
  end

  assign dout = stage[SHAMT_W];

endmodule

// File: rtl/shift_sched.sv
// Round-robin two-requester scheduler around one shared barrel_right instance.
// Define SHIFT_SCHED_ROTATE_EN to honour reqN_rot (rotate = right shift + reversed left pass).
module shift_sched #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req0_rot,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic               req1_rot,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [DATA_W-1:0]  rsp0_data,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [DATA_W-1:0]  rsp1_data
);

  import shift_sched_pkg::*;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               owner_q, owner_d;
  logic [DATA_W-1:0]  op_data_q, op_data_d;
  logic [SHAMT_W-1:0] op_shamt_q, op_shamt_d;
  logic [DATA_W-1:0]  res_q, res_d;

  logic               gnt;
  logic               gnt_any;
  logic               req_fire;
  logic               rsp_fire;
  logic [DATA_W-1:0]  sh_in;
  logic [SHAMT_W-1:0] sh_amt;
  logic [DATA_W-1:0]  sh_out;

`ifdef SHIFT_SCHED_ROTATE_EN
  logic op_rot_q, op_rot_d;
`else
  logic unused_rot;
  assign unused_rot = req0_rot ^ req1_rot;
`endif

  // On a tie the requester that did not win last time is granted.
  assign gnt_any    = req0_valid | req1_valid;
  assign gnt        = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign req0_ready = (state_q == IDLE) & gnt_any & ~gnt;
  assign req1_ready = (state_q == IDLE) & gnt_any & gnt;
  assign req_fire   = req0_ready | req1_ready;

  assign rsp0_valid = (state_q == DONE) & ~owner_q;
  assign rsp1_valid = (state_q == DONE) & owner_q;
  assign rsp0_data  = res_q;
  assign rsp1_data  = res_q;
  assign rsp_fire   = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    sh_in  = op_data_q;
    sh_amt = op_shamt_q;
`ifdef SHIFT_SCHED_ROTATE_EN
    // Second pass builds op_data << (16 - s) by shifting the reversed operand right.
    if (state_q == PASS2) begin
      sh_in  = bitrev16(op_data_q);
      sh_amt = -op_shamt_q;
    end
`endif
  end

  barrel_right #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_barrel_right (
    .din   (sh_in),
    .shamt (sh_amt),
    .dout  (sh_out)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_data_d    = op_data_q;
    op_shamt_d   = op_shamt_q;
    res_d        = res_q;
`ifdef SHIFT_SCHED_ROTATE_EN
    op_rot_d     = op_rot_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          owner_d      = gnt;
          last_grant_d = gnt;
          op_data_d    = gnt ? req1_data : req0_data;
          op_shamt_d   = gnt ? req1_shamt : req0_shamt;
`ifdef SHIFT_SCHED_ROTATE_EN
          op_rot_d     = gnt ? req1_rot : req0_rot;
`endif
          state_d      = PASS1;
        end
      end
      PASS1: begin
        res_d   = sh_out;
        state_d = DONE;
`ifdef SHIFT_SCHED_ROTATE_EN
        if (op_rot_q && (op_shamt_q != '0)) begin
          state_d = PASS2;
        end
`endif
      end
`ifdef SHIFT_SCHED_ROTATE_EN
      PASS2: begin
        res_d   = res_q | bitrev16(sh_out);
        state_d = DONE;
      end
`endif
      DONE: begin
        if (rsp_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_data_q    <= '0;
      op_shamt_q   <= '0;
      res_q        <= '0;
`ifdef SHIFT_SCHED_ROTATE_EN
      op_rot_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_data_q    <= op_data_d;
      op_shamt_q   <= op_shamt_d;
      res_q        <= res_d;
`ifdef SHIFT_SCHED_ROTATE_EN
      op_rot_q     <= op_rot_d;
`endif
    end
  end

endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench for shift_sched: directed test-plan steps followed by random traffic
// checked against an arithmetic shift/rotate and round-robin model.
module tb_shift_sched;

  import shift_sched_pkg::*;

`ifdef SHIFT_SCHED_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_data = '0, req1_data = '0;
  logic [3:0]  req0_shamt = '0, req1_shamt = '0;
  logic        req0_rot = 1'b0, req1_rot = 1'b0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [15:0] rsp0_data, rsp1_data;

  int n_cmp  = 0;
  int n_fail = 0;
  int lg     = 1;

  always #5 clk = ~clk;

  shift_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_shamt (req0_shamt),
    .req0_rot   (req0_rot),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_shamt (req1_shamt),
    .req1_rot   (req1_rot),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  function automatic logic rspv(input int r);
    return (r != 0) ? rsp1_valid : rsp0_valid;
  endfunction

  function automatic logic [15:0] rspd(input int r);
    return (r != 0) ? rsp1_data : rsp0_data;
  endfunction

  // Reference: logical right shift, or rotate right when enabled.
  function automatic logic [15:0] model_res(input logic [15:0] d, input logic [3:0] s, input logic rot);
    int unsigned x;
    int unsigned y;
    x = 32'(d);
    y = x >> s;
    if (ROT_EN && rot && s != 0) y = y | (x << (16 - int'(s)));
    return y[15:0];
  endfunction

  function automatic int model_lat(input logic [3:0] s, input logic rot);
    return (ROT_EN && rot && s != 0) ? 3 : 2;
  endfunction

  task automatic set_req(input int r, input logic v, input logic [15:0] d, input logic [3:0] s, input logic rot);
    if (r != 0) begin
      req1_valid = v; req1_data = d; req1_shamt = s; req1_rot = rot;
    end else begin
      req0_valid = v; req0_data = d; req0_shamt = s; req0_rot = rot;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lg = 1;
    #1;
  endtask

  // Requester `own` must be granted now; follows it through to the consumed response.
  task automatic serve(input int own, input logic [15:0] want, input int want_lat, input int hold);
    int lat;
    logic [15:0] held;
    chk("grant_ready", (own != 0) ? req1_ready : req0_ready, 1);
    chk("other_ready", (own != 0) ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;
    if (own != 0) begin
      req1_valid = 1'b0; req1_data = 16'($urandom);
    end else begin
      req0_valid = 1'b0; req0_data = 16'($urandom);
    end
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      #1;
      if (rspv(own)) lat = k;
      else begin
        chk("busy_ready", {req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
      end
    end
    chk("latency", lat, want_lat);
    chk("rsp_data", rspd(own), want);
    chk("other_rsp_valid", rspv(1 - own), 0);
    held = rspd(own);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #2;
      chk("hold_valid", rspv(own), 1);
      chk("hold_data", rspd(own), held);
      chk("hold_ready", {req0_ready, req1_ready}, 0);
    end
    if (own != 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #1;
    chk("idle_after_rsp", 32'(dut.state_q), 32'(IDLE));
    chk("rsp_dropped", rspv(own), 0);
    $display("op: owner=%0d result=0x%04h latency=%0d hold=%0d", own, held, lat, hold);
    lg = own;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] dd [2];
    logic [3:0]  ss [2];
    logic        rr [2];
    int mask;
    int w;

    // Reset state
    do_reset();
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_data", rsp0_data, 0);
    chk("rst_rsp1_data", rsp1_data, 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_ready_none", {req0_ready, req1_ready}, 0);
    set_req(0, 1'b1, 16'h8000, 4'd15, 1'b0);
    #1;
    chk("rst_req0_ready", req0_ready, 1);

    // Plain shifts
    serve(0, 16'h0001, 2, 0);
    set_req(1, 1'b1, 16'hF0F0, 4'd0, 1'b0);
    #1;
    serve(1, 16'hF0F0, 2, 0);

    // Tie from reset: requester 0 first, requester 1 the cycle after
    set_req(0, 1'b1, 16'h00FF, 4'd4, 1'b0);
    set_req(1, 1'b1, 16'hFF00, 4'd8, 1'b0);
    do_reset();
    serve(0, 16'h000F, 2, 0);
    serve(1, 16'h00FF, 2, 0);

    // Backpressure on requester 1 while requester 0 waits
    set_req(0, 1'b1, 16'h0F0F, 4'd1, 1'b0);
    #1;
    serve(0, 16'h0787, 2, 0);
    set_req(0, 1'b1, 16'h8001, 4'd15, 1'b0);
    set_req(1, 1'b1, 16'hABCD, 4'd5, 1'b0);
    #1;
    serve(1, 16'h055E, 2, 5);
    serve(0, 16'h0001, 2, 0);

    // Rotate (or plain shift when rotate support is compiled out)
    set_req(0, 1'b1, 16'h1234, 4'd4, 1'b1);
    #1;
    serve(0, ROT_EN ? 16'h4123 : 16'h0123, ROT_EN ? 3 : 2, 0);
    set_req(0, 1'b1, 16'h1234, 4'd0, 1'b1);
    #1;
    serve(0, 16'h1234, 2, 0);

    // Reset in PASS1 discards the operation
    set_req(0, 1'b1, 16'hABCD, 4'd3, 1'b1);
    #1;
    chk("midrst_ready", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_pass1", 32'(dut.state_q), 32'(PASS1));
    @(posedge clk); #1;
    rst = 1'b0;
    lg = 1;
    #1;
    chk("midrst_idle", 32'(dut.state_q), 32'(IDLE));
    for (int c = 0; c < 4; c++) begin
      chk("midrst_no_rsp", {rsp0_valid, rsp1_valid}, 0);
      @(posedge clk); #2;
    end
    set_req(1, 1'b1, 16'h00F0, 4'd4, 1'b0);
    #1;
    serve(1, 16'h000F, 2, 0);

    // Random traffic against the model
    for (int it = 0; it < 40; it++) begin
      mask = int'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        dd[r] = 16'($urandom);
        ss[r] = 4'($urandom);
        rr[r] = 1'($urandom);
        set_req(r, mask[r], dd[r], ss[r], rr[r]);
      end
      #1;
      w = (mask == 3) ? ((lg != 0) ? 0 : 1) : ((mask == 2) ? 1 : 0);
      serve(w, model_res(dd[w], ss[w], rr[w]), model_lat(ss[w], rr[w]), int'($urandom_range(0, 2)));
      if (mask == 3) begin
        serve(1 - w, model_res(dd[1-w], ss[1-w], rr[1-w]), model_lat(ss[1-w], rr[1-w]),
              int'($urandom_range(0, 2)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sched.md
# shift_sched

Two-requester scheduler for the ALU's single 16-bit logical right barrel shifter. Round-robin arbitration grants one requester at a time. The scheduler sequences the shared `barrel_right` instance over one or two passes and returns a registered result through a valid/ready response channel. It sits between the ALU issue logic (requester 0) and the address-generation unit (requester 1).

## Interface
Parameters:
- DATA_W, 16, operand width; only 16 is supported, because the shared shifter is fixed at 16 bits
- SHAMT_W, 4, shift-amount width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous and active-high
- reqN_valid  in  1  requester N (N = 0, 1) presents an operation
- reqN_ready  out  1  scheduler accepts requester N's operation this cycle
- reqN_data  in  16  operand
- reqN_shamt  in  4  shift amount, 0..15
- reqN_rot  in  1  1 = rotate right; ignored unless SHIFT_SCHED_ROTATE_EN is defined
- rspN_valid  out  1  result for requester N is valid
- rspN_ready  in  1  requester N consumes the result
- rspN_data  out  16  result

## Operation
- States: IDLE, PASS1, PASS2, DONE.
- IDLE:
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the requester other than last_grant is granted.
  - reqN_ready is high only in IDLE and only for the granted requester, so it is combinational from the valids and last_grant.
  - On handshake: latch op_data, op_shamt, op_rot (forced to 0 without the macro) and owner; update last_grant to owner; go to PASS1.
- PASS1:
  - The shifter is driven with op_data and op_shamt; its output is captured in res.
  - If op_rot = 1 and op_shamt != 0, go to PASS2; otherwise go to DONE.
- PASS2 (rotate only):
  - The shifter is driven with bitrev(op_data) and shamt 16 - op_shamt, truncated to 4 bits, which is valid for op_shamt 1..15.
  - res <= res | bitrev(shifter_out). This equals (op_data << (16 - s)) OR'd with pass 1, i.e. the rotate result.
  - Go to DONE.
- DONE:
  - rsp{owner}_valid = 1 and rsp{owner}_data = res.
  - On rsp{owner}_ready, go to IDLE.
  - The other rsp valid stays 0.
- Shifts are logical; vacated bits are zero.
- Shift amount 0 returns the operand unchanged. A rotate by 0 skips PASS2.
- A requester may hold reqN_valid while the other requester is being served. Its operands must stay stable until its handshake.

## Timing
- Reset values: state IDLE, last_grant 1 (so requester 0 wins the first tie), res 0, rsp0/1_valid 0, rsp0/1_data 0, req0/1_ready 0 except as decoded in IDLE after reset.
- Latency, with the request handshake at cycle T:
  - Shift: rspN_valid is high from cycle T+2.
  - Rotate with s != 0: rspN_valid is high from cycle T+3.
- The response is held, with data stable, until ready. Response handshake at cycle R means the state is IDLE at R+1, and a new request can be accepted at R+1.
- Maximum throughput is one operation per 3 cycles.
- No request is accepted while an operation is in flight.
- rst during any state returns to IDLE on the next edge and discards the operation. No response is issued for it.
- A requester that drops reqN_valid before its handshake loses nothing; no state is held for it.

## Configuration
- SHIFT_SCHED_ROTATE_EN
  - Defined: reqN_rot is honoured, the PASS2 state exists and rotate latency applies.
  - Undefined: op_rot is tied to 0, PASS2 and the bit-reverse logic are not compiled, and every operation is a logical right shift with 2-cycle latency.

## Structure
- Package shift_sched_pkg contains:
  - DATA_W and SHAMT_W constants
  - state enum typedef (IDLE, PASS1, PASS2, DONE)
  - bitrev16 function
- The single sub-module is one instance of the existing `barrel_right`. Its input and shamt mux is selected by state.

## Test plan
- Reset: assert rst for 2 cycles. All rspN_valid = 0, all rspN_data = 0 and state IDLE. req0_ready is 1 when only req0_valid = 1.
- Shift: req0 0x8000 with shamt 15. rsp0_valid at T+2 with data 0x0001. Also req1 0xF0F0 with shamt 0 returns 0xF0F0 at T+2.
- Tie: req0 (0x00FF, 4) and req1 (0xFF00, 8) both valid from reset.
  - req0 is served first with 0x000F.
  - req1 is accepted the cycle after rsp0 is consumed and returns 0x00FF.
- Backpressure: hold rsp1_ready low for 5 cycles. rsp1_valid and rsp1_data stay stable, and req0_ready stays 0 throughout.
- Rotate with the macro defined: 0x1234 with shamt 4 gives 0x4123 at T+3. A rotate by 0 returns 0x1234 at T+2. Without the macro, the first case gives 0x0123 at T+2.
- Reset mid-operation: assert rst in PASS1. The next cycle is IDLE, no rsp valid is ever asserted, and a new request completes normally.
